// File: rtl/cycle_timer_pkg.sv
// Shared 4004 timing definitions: machine-state encodings
// A1..X3 and the sub-phase constants used by the timer and CPU decode.
package cycle_timer_pkg;

  typedef enum logic [2:0] {
    A1 = 3'd0,
    A2 = 3'd1,
    A3 = 3'd2,
    M1 = 3'd3,
    M2 = 3'd4,
    X1 = 3'd5,
    X2 = 3'd6,
    X3 = 3'd7
  } cyc_state_t;

  localparam logic [1:0] SUBPH_PHI1 = 2'd0;
  localparam logic [1:0] SUBPH_PHI2 = 2'd2;
  localparam logic [1:0] SUBPH_LAST = 2'd3;

  function automatic cyc_state_t next_state(cyc_state_t s);
    return cyc_state_t'(s + 3'd1);
  endfunction

endpackage

// File: rtl/cycle_timer_if.sv
// Timer bus: divider tick, run/step requests in; timing strobes out.
// master drives tc/runReq(/stepReq); slave is the cycle_timer.
interface cycle_timer_if;
  logic       tc;
  logic       runReq;
`ifdef CYCLE_TIMER_SINGLE_STEP_EN
  logic       stepReq;
`endif
  logic [2:0] cycState;
  logic [1:0] subPh;
  logic       phi1;
  logic       phi2;
  logic       sync;
  logic       stateStrobe;
  logic       cycleDone;
  logic       running;

  modport master (
`ifdef CYCLE_TIMER_SINGLE_STEP_EN
    output stepReq,
`endif
    output tc, runReq,
    input  cycState, subPh, phi1, phi2,
    input  sync, stateStrobe, cycleDone, running
  );

  modport slave (
`ifdef CYCLE_TIMER_SINGLE_STEP_EN
    input  stepReq,
`endif
    input  tc, runReq,
    output cycState, subPh, phi1, phi2,
    output sync, stateStrobe, cycleDone, running
  );
endinterface

// File: rtl/cycle_timer_edge_detect.sv
// Registered rising-edge detector (clk, rstN, d in; rise out).
// Present only when CYCLE_TIMER_SINGLE_STEP_EN is defined.
`ifdef CYCLE_TIMER_SINGLE_STEP_EN
module cycle_timer_edge_detect (
  input  logic clk,
  input  logic rstN,
  input  logic d,
  output logic rise
);
  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= d;
      rise_q <= d & ~prev_q;
    end
  end

  assign rise = rise_q;
endmodule
`endif

// File: rtl/cycle_timer.sv
// 4004 instruction-cycle timer: 8 states x 4 sub-phases per cycle,
// gated by tc, run/halt on cycle boundary. Ports: clk, rstN, bus
// (cycle_timer_if.slave). Option: CYCLE_TIMER_SINGLE_STEP_EN adds stepReq.
module cycle_timer
  import cycle_timer_pkg::*;
#(
  parameter bit RUN_ON_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         rstN,
  cycle_timer_if.slave bus
);

  cyc_state_t st_q, st_d;
  logic [1:0] sub_q, sub_d;
  logic       run_q, run_d;
  logic       done_q, done_d;

  logic last;
  logic adv;
  logic wrap;
  logic start;
  logic go;
  logic stop;

`ifdef CYCLE_TIMER_SINGLE_STEP_EN
  logic rise;
  logic armed_q, armed_d;
  logic step_q, step_d;

  cycle_timer_edge_detect u_edge (
    .clk  (clk),
    .rstN (rstN),
    .d    (bus.stepReq),
    .rise (rise)
  );

  // a step cycle always re-halts at the wrap
  assign go   = bus.runReq | armed_q;
  assign stop = ~bus.runReq | step_q;
`else
  assign go   = bus.runReq;
  assign stop = ~bus.runReq;
`endif

  assign last  = (sub_q == SUBPH_LAST);
  assign adv   = bus.tc & run_q;
  assign wrap  = adv & last & (st_q == X3);
  assign start = bus.tc & ~run_q & go;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      st_q   <= A1;
      sub_q  <= SUBPH_PHI1;
      run_q  <= RUN_ON_RESET;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      sub_q  <= sub_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    sub_d  = sub_q;
    run_d  = run_q;
    done_d = wrap;
    unique case (1'b1)
      adv: begin
        sub_d = sub_q + 2'd1;
        if (last) st_d = next_state(st_q);
        if (wrap && stop) run_d = 1'b0;
      end
      start: run_d = 1'b1;
      default: ;
    endcase
  end

`ifdef CYCLE_TIMER_SINGLE_STEP_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      armed_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      armed_q <= armed_d;
      step_q  <= step_d;
    end
  end

  // edges while running are dropped, not queued
  always_comb begin
    armed_d = armed_q;
    step_d  = step_q;
    if (rise && !run_q) armed_d = 1'b1;
    if (start) begin
      armed_d = 1'b0;
      step_d  = armed_q;
    end
    if (wrap) step_d = 1'b0;
  end
`endif

  assign bus.cycState    = st_q;
  assign bus.subPh       = sub_q;
  assign bus.running     = run_q;
  assign bus.cycleDone   = done_q;
  assign bus.phi1        = run_q & (sub_q == SUBPH_PHI1);
  assign bus.phi2        = run_q & (sub_q == SUBPH_PHI2);
  assign bus.sync        = run_q & (st_q == X3);
  assign bus.stateStrobe = bus.tc & run_q & last;

endmodule

// File: doc/cycle_timer.md
Name: cycle_timer

Overview:
- Consumes the terminal-count tick from the clock divider and generates the 4004 instruction-cycle timing for the CPU core.
- Timing comprises 8 machine states (A1 A2 A3 M1 M2 X1 X2 X3), each split into 4 sub-phases, giving non-overlapping phi1/phi2 strobes and SYNC.
- Adds run/halt control: halting only takes effect on an instruction-cycle boundary, so the core never stops mid-cycle.

Parameters:
- RUN_ON_RESET, default 1: 1 = running after reset release; 0 = halted at A1 until runReq is seen.

Ports:
- clk  input  1  system clock
- rstN  input  1  asynchronous active-low reset
- tc  input  1  tick enable from divider; may be high on consecutive clocks, or continuously
- runReq  input  1  level; 1 = run, 0 = halt at next cycle boundary
- cycState  output  3  current machine state: A1=0 A2=1 A3=2 M1=3 M2=4 X1=5 X2=6 X3=7
- subPh  output  2  sub-phase within the state (0..3)
- phi1  output  1  high while running && subPh==0
- phi2  output  1  high while running && subPh==2
- sync  output  1  high while running && cycState==X3
- stateStrobe  output  1  tc && running && subPh==3, i.e. the last tick of a state; the CPU latches on it
- cycleDone  output  1  registered 1-clk pulse after the X3→A1 wrap
- running  output  1  1 = sequencing, 0 = halted

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, ports clk / rstN.
- Reset values: cycState=A1, subPh=0, running=RUN_ON_RESET, cycleDone=0. Derived outputs follow from these; sync=0 and phi2=0 at reset.
- Sequencing: all advancement is gated by tc. Clocks with tc=0 hold every register.
- While running, on a tc clock:
  - subPh increments mod 4.
  - When subPh==3, subPh goes to 0 and cycState advances (X3 wraps to A1).
- Cycle length: 32 tc ticks per instruction cycle; 4 ticks per state.
- Halt decision: runReq is sampled only on the tc clock at X3/subPh==3.
  - runReq=0: wrap to A1/0 still occurs, then running←0 on the same edge, and cycleDone pulses next clk.
  - runReq=1: continue normally.
- Halted state: cycState=A1 and subPh=0 are held; phi1, phi2, sync and stateStrobe are all 0.
- Resume: on any tc clock with runReq=1, running←1. The first phi1 (A1/0) is visible on the following clock. A1 then lasts a full 4 ticks.
- Mid-cycle runReq drop: runReq falling anywhere other than the sampling point has no effect; the cycle completes.
- Continuous tc (divider maxCount=0): a state lasts 4 clks and a cycle 32 clks. No skipped states.
- Mid-operation reset: immediate return to reset values. There is no partial-cycle memory.
- Outputs phi1, phi2, sync and stateStrobe are combinational decodes of registered state; cycleDone is registered.
- Widths: cycState 3-bit and subPh 2-bit use natural wrap; no other arithmetic.

Optional Feature:
- Macro: CYCLE_TIMER_SINGLE_STEP_EN.
- Defined:
  - Adds input stepReq (1 bit, may be asynchronous to run logic but in the clk domain).
  - stepReq is rising-edge detected internally.
  - While halted, a rising edge arms one step. The next tc sets running=1 for exactly one instruction cycle (32 ticks). The block then re-halts at the wrap regardless of runReq. cycleDone pulses as normal.
  - Edges seen while running are ignored (not queued).
- Undefined: no stepReq port, no edge-detect logic; halt/resume via runReq only.

Decomposition:
- Shared definitions include, tb4004_timing_defs: state encodings A1..X3, SUBPH_PHI1=0, SUBPH_PHI2=2, SUBPH_LAST=3. The CPU decode logic uses the same constants.
- Sub-module edge_detect (registered rising-edge detector, clk/rstN): instantiated only under CYCLE_TIMER_SINGLE_STEP_EN.
- Everything else stays flat.

Test Plan:
- Reset with tc held 1, RUN_ON_RESET=1, runReq=1 → phi1 at clk 0, phi2 at clk 2, cycState steps 0..7 every 4 clks, sync high clks 28-31, cycleDone at clk 32.
- tc every 3rd clk, running → each state spans 12 clks; phi1/phi2 never high together; stateStrobe exactly once per state, coincident with tc.
- Drop runReq at M1 → cycle finishes through X3, wraps to A1, running=0, cycleDone=1 for one clk; outputs frozen (phi1=0) for 100 clks with tc toggling.
- From halt, raise runReq at a tc clock → running=1 next edge, phi1 on following clock, full 32-tick cycle follows.
- Assert rstN=0 mid-X1/subPh 2 → cycState=0, subPh=0, sync=0, cycleDone=0 asynchronously; resumes from A1 after release.
- With CYCLE_TIMER_SINGLE_STEP_EN, halted, runReq=0, pulse stepReq → exactly 32 tc ticks run, one cycleDone, re-halt; a second stepReq pulse during the step is ignored.
